serial_stream: RTL and testbench

//  Parallel-to-serial stream converter, generalised successor of the single-bit serialiser.

---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_stream_cnt.sv | 27 ++
 rtl/serial_stream.sv | 115 +++++++++++
 tb/tb_serial_stream.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and elaboration helpers for the parallel-to-serial stream converter.
package serial_pkg;

    typedef enum logic {S_IDLE, S_SHIFT} serial_state_t;

    function automatic int f_beats(input int width, input int lanes);
        return width / lanes;
    endfunction

    function automatic int f_cntw(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/serial_stream_cnt.sv
// Wrapping beat counter: counts 0..p_scale, clear has priority over increment.
module serial_stream_cnt #(
    parameter int p_scale = 7,
    parameter int p_cw    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [p_cw-1:0] cnt,
    output logic            wrap
);

    assign wrap = (cnt == p_cw'(p_scale));

    // Count register; wraps back to zero after the terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + p_cw'(1);
        end
    end

endmodule

// File: rtl/serial_stream.sv
// Parallel-to-serial converter with one-word holding buffer and step-paced beats.
module serial_stream
    import serial_pkg::*;
#(
    parameter int p_width     = 8,
    parameter int p_lanes     = 1,
    parameter bit p_msb_first = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [p_width-1:0] i_dat,
    input  logic               i_vld,
    output logic               o_rdy,
    input  logic               i_stp,
    output logic [p_lanes-1:0] o_val,
    output logic               o_act,
    output logic               o_first,
    output logic               o_last,
    output logic               o_done
);

    localparam int p_beats = f_beats(p_width, p_lanes);
    localparam int p_cw    = f_cntw(p_beats);

    if ((p_width % p_lanes) != 0) begin : g_chk
        $error("serial_stream: p_width must be a multiple of p_lanes");
    end

    serial_state_t      state;
    logic [p_width-1:0] hold;
    logic [p_width-1:0] sh;
    logic [p_width-1:0] sh_next;
    logic [p_lanes-1:0] lane;
    logic               hold_full;
    logic               done;
    logic [p_cw-1:0]    cnt;
    logic               wrap;
    logic               act;
    logic               accept;
    logic               w_load;

    assign act     = (state == S_SHIFT);
    assign o_act   = act;
    assign o_first = act & (cnt == '0);
    assign o_last  = act & wrap;
    assign o_done  = done;

    // A word moves into the shifter when idle or on the final step of the current word.
    assign w_load = hold_full & (~act | (i_stp & o_last));
    assign o_rdy  = ~i_rst & (~hold_full | w_load);
    assign accept = i_vld & o_rdy;

    if (p_msb_first) begin : g_msb
        assign lane    = sh[p_width-1 -: p_lanes];
        assign sh_next = sh << p_lanes;
    end else begin : g_lsb
        assign lane    = sh[p_lanes-1:0];
        assign sh_next = sh >> p_lanes;
    end

    assign o_val = act ? lane : '0;

    serial_stream_cnt #(
        .p_scale (p_beats - 1),
        .p_cw    (p_cw)
    ) u_cnt (
        .clk  (i_clk),
        .rst  (i_rst),
        .clr  (w_load),
        .inc  (i_stp & act),
        .cnt  (cnt),
        .wrap (wrap)
    );

    // Handshake buffer, shifter and IDLE/SHIFT state machine.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            sh        <= '0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            hold_full <= accept | (hold_full & ~w_load);
            if (accept) begin
                hold <= i_dat;
            end
            case (state)
                S_IDLE: begin
                    if (w_load) begin
                        sh    <= hold;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (i_stp) begin
                        if (o_last) begin
                            if (hold_full) begin
                                sh <= hold;
                            end else begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            sh <= sh_next;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_stream.sv
// Directed self-checking bench for serial_stream in three configurations.
module tb_serial_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: w8 l1 LSB-first
    logic [7:0] dat_a = 8'h00;
    logic       vld_a = 1'b0, stp_a = 1'b0;
    logic       rdy_a, val_a, act_a, first_a, last_a, done_a;
    // Instance B: w8 l2 MSB-first
    logic [7:0] dat_b = 8'h00;
    logic       vld_b = 1'b0, stp_b = 1'b0;
    logic       rdy_b, act_b, first_b, last_b, done_b;
    logic [1:0] val_b;
    // Instance C: w8 l8 (single beat)
    logic [7:0] dat_c = 8'h00;
    logic       vld_c = 1'b0, stp_c = 1'b0;
    logic       rdy_c, act_c, first_c, last_c, done_c;
    logic [7:0] val_c;

    int checks = 0;
    int errors = 0;

    serial_stream #(.p_width(8), .p_lanes(1), .p_msb_first(1'b0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_dat(dat_a), .i_vld(vld_a), .o_rdy(rdy_a),
        .i_stp(stp_a), .o_val(val_a), .o_act(act_a), .o_first(first_a),
        .o_last(last_a), .o_done(done_a));

    serial_stream #(.p_width(8), .p_lanes(2), .p_msb_first(1'b1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_dat(dat_b), .i_vld(vld_b), .o_rdy(rdy_b),
        .i_stp(stp_b), .o_val(val_b), .o_act(act_b), .o_first(first_b),
        .o_last(last_b), .o_done(done_b));

    serial_stream #(.p_width(8), .p_lanes(8), .p_msb_first(1'b0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_dat(dat_c), .i_vld(vld_c), .o_rdy(rdy_c),
        .i_stp(stp_c), .o_val(val_c), .o_act(act_c), .o_first(first_c),
        .o_last(last_c), .o_done(done_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] w;
    logic [7:0] w2;
    logic [1:0] t2_exp [8] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    logic [7:0] t5_d   [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};

    initial begin
        // Reset state
        tick;
        tick;
        chk("rst_rdy_a", 32'(rdy_a), 32'd0);
        chk("rst_act_a", 32'(act_a), 32'd0);
        chk("rst_val_c", 32'(val_c), 32'd0);
        chk("rst_done_b", 32'(done_b), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_rdy_a", 32'(rdy_a), 32'd1);
        chk("rel_rdy_c", 32'(rdy_c), 32'd1);

        // T1: 0xA5 LSB-first, step every cycle
        w = 8'hA5;
        dat_a = w; vld_a = 1'b1; stp_a = 1'b1;
        tick;
        vld_a = 1'b0;
        chk("t1_act_lat", 32'(act_a), 32'd0);
        tick;
        for (int i = 0; i < 8; i++) begin
            chk("t1_val", 32'(val_a), 32'(w[i]));
            chk("t1_first", 32'(first_a), 32'(i == 0));
            chk("t1_last", 32'(last_a), 32'(i == 7));
            chk("t1_nodone", 32'(done_a), 32'd0);
            tick;
        end
        chk("t1_done", 32'(done_a), 32'd1);
        chk("t1_act_end", 32'(act_a), 32'd0);
        tick;
        chk("t1_done_pulse", 32'(done_a), 32'd0);

        // T2: 0x0F then 0xF0 back-to-back, 2 lanes MSB-first
        dat_b = 8'h0F; vld_b = 1'b1; stp_b = 1'b1;
        tick;
        dat_b = 8'hF0;
        chk("t2_rdy2", 32'(rdy_b), 32'd1);
        tick;
        vld_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t2_val", 32'(val_b), 32'(t2_exp[i]));
            chk("t2_act", 32'(act_b), 32'd1);
            chk("t2_nodone", 32'(done_b), 32'd0);
            chk("t2_first", 32'(first_b), 32'(i == 0 || i == 4));
            tick;
        end
        chk("t2_done", 32'(done_b), 32'd1);
        stp_b = 1'b0;
        tick;
        chk("t2_done_once", 32'(done_b), 32'd0);

        // T3: 0x3C with a step every third cycle
        w = 8'h3C;
        stp_a = 1'b0;
        dat_a = w; vld_a = 1'b1;
        tick;
        vld_a = 1'b0;
        tick;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 3; k++) begin
                stp_a = (k == 2);
                chk("t3_val", 32'(val_a), 32'(w[b]));
                chk("t3_act", 32'(act_a), 32'd1);
                tick;
            end
        end
        stp_a = 1'b0;
        chk("t3_done", 32'(done_a), 32'd1);

        // T4: backpressure with three words presented
        w = 8'h11;
        w2 = 8'h22;
        dat_a = w; vld_a = 1'b1;
        tick;
        dat_a = w2;
        tick;
        chk("t4_rdy_full", 32'(rdy_a), 32'd0);
        dat_a = 8'h33;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t4_rdy_hold", 32'(rdy_a), 32'd0);
            chk("t4_val_hold", 32'(val_a), 32'd1);
            chk("t4_first_hold", 32'(first_a), 32'd1);
        end
        stp_a = 1'b1;
        for (int b = 0; b < 8; b++) begin
            chk("t4_w1_val", 32'(val_a), 32'(w[b]));
            chk("t4_rdy_step", 32'(rdy_a), 32'(b == 7));
            tick;
        end
        vld_a = 1'b0;
        for (int b = 0; b < 8; b++) begin
            chk("t4_w2_val", 32'(val_a), 32'(w2[b]));
            tick;
        end
        w = 8'h33;
        for (int b = 0; b < 8; b++) begin
            chk("t4_w3_val", 32'(val_a), 32'(w[b]));
            chk("t4_w3_act", 32'(act_a), 32'd1);
            tick;
        end
        chk("t4_done", 32'(done_a), 32'd1);
        stp_a = 1'b0;

        // T5: single-beat words, one per cycle
        stp_c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dat_c = t5_d[i]; vld_c = 1'b1;
            chk("t5_rdy", 32'(rdy_c), 32'd1);
            tick;
            if (i >= 1) begin
                chk("t5_val", 32'(val_c), 32'(t5_d[i-1]));
                chk("t5_first", 32'(first_c), 32'd1);
                chk("t5_last", 32'(last_c), 32'd1);
                chk("t5_nodone", 32'(done_c), 32'd0);
            end
        end
        vld_c = 1'b0;
        tick;
        chk("t5_val_end", 32'(val_c), 32'(t5_d[7]));
        chk("t5_nodone_end", 32'(done_c), 32'd0);
        tick;
        chk("t5_done", 32'(done_c), 32'd1);
        chk("t5_act_end", 32'(act_c), 32'd0);
        stp_c = 1'b0;

        // T6: reset at beat 4 of 0xFF with the holding buffer full
        dat_a = 8'hFF; vld_a = 1'b1;
        tick;
        dat_a = 8'hAA;
        tick;
        vld_a = 1'b0;
        stp_a = 1'b1;
        repeat (4) tick;
        chk("t6_val_mid", 32'(val_a), 32'd1);
        chk("t6_rdy_mid", 32'(rdy_a), 32'd0);
        rst = 1'b1;
        tick;
        chk("t6_act_rst", 32'(act_a), 32'd0);
        chk("t6_val_rst", 32'(val_a), 32'd0);
        chk("t6_rdy_rst", 32'(rdy_a), 32'd0);
        chk("t6_done_rst", 32'(done_a), 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_rdy_rel", 32'(rdy_a), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("t6_no_act", 32'(act_a), 32'd0);
            chk("t6_no_val", 32'(val_a), 32'd0);
            chk("t6_no_done", 32'(done_a), 32'd0);
        end
        stp_a = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
